// File: rtl/oled_text.sv
// Character-cell text renderer: holds a screen of character codes and answers per-column
// pixel requests through an external glyph ROM with 3-cycle latency. Macro: OLED_TEXT_CURSOR_EN.
module oled_text #(
  parameter int SCREEN_WIDTH  = 128,
  parameter int SCREEN_HEIGHT = 64,
  parameter int TILE_WIDTH    = 8,
  parameter int CHAR_BITS     = 7,
  parameter int BLINK_CYCLES  = 13_500_000,
  localparam int NUM_TILES_X   = SCREEN_WIDTH / TILE_WIDTH,
  localparam int SCREEN_PAGES  = SCREEN_HEIGHT / 8,
  localparam int NUM_TILES     = NUM_TILES_X * SCREEN_PAGES,
  localparam int HCTR_BITS     = $clog2(SCREEN_WIDTH),
  localparam int PAGE_BITS     = $clog2(SCREEN_PAGES),
  localparam int COL_BITS      = $clog2(TILE_WIDTH),
  localparam int TILE_NUM_BITS = $clog2(NUM_TILES),
  localparam int TILE_X_BITS   = $clog2(NUM_TILES_X)
) (
  input  logic                   in_clk,
  input  logic                   in_rst_n,
  input  logic                   in_pix_req,
  input  logic [HCTR_BITS-1:0]   in_hpix,
  input  logic [PAGE_BITS-1:0]   in_vpage,
  output logic [7:0]             out_pixels,
  output logic                   out_pix_valid,
  output logic [CHAR_BITS-1:0]   out_font_char,
  output logic [COL_BITS-1:0]    out_font_col,
  input  logic [7:0]             in_font_column,
  input  logic [CHAR_BITS-1:0]   in_char,
  input  logic                   in_char_valid,
  output logic                   out_char_ready,
  input  logic                   in_clear,
  output logic [TILE_X_BITS-1:0] out_cursor_x,
  output logic [PAGE_BITS-1:0]   out_cursor_y
);

  localparam logic [CHAR_BITS-1:0] CH_SPACE = CHAR_BITS'(8'h20);
  localparam logic [CHAR_BITS-1:0] CH_LF    = CHAR_BITS'(8'h0A);
  localparam logic [CHAR_BITS-1:0] CH_CR    = CHAR_BITS'(8'h0D);
  localparam logic [CHAR_BITS-1:0] CH_BS    = CHAR_BITS'(8'h08);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                   state_reg, state_next;
  logic [TILE_NUM_BITS-1:0] clr_addr_reg, clr_addr_next;
  logic [TILE_X_BITS-1:0]   cursor_x_reg, cursor_x_next;
  logic [PAGE_BITS-1:0]     cursor_y_reg, cursor_y_next;

  logic                     wr_en;
  logic [TILE_NUM_BITS-1:0] wr_addr;
  logic [CHAR_BITS-1:0]     wr_data;
  logic [TILE_NUM_BITS-1:0] cursor_tile;
  logic [PAGE_BITS-1:0]     cursor_y_inc;

  logic [CHAR_BITS-1:0] text_mem [NUM_TILES];

  logic [TILE_NUM_BITS-1:0] pix_tile;
  logic [COL_BITS-1:0]      pix_col;
  logic [CHAR_BITS-1:0]     font_char_reg;
  logic [COL_BITS-1:0]      font_col_reg;
  logic                     req_d1_reg, req_d2_reg, pix_valid_reg;
  logic [7:0]               pixels_reg;

  assign cursor_tile  = TILE_NUM_BITS'(cursor_y_reg) * TILE_NUM_BITS'(NUM_TILES_X)
                      + TILE_NUM_BITS'(cursor_x_reg);
  assign cursor_y_inc = (cursor_y_reg == PAGE_BITS'(SCREEN_PAGES - 1))
                      ? '0 : cursor_y_reg + 1'b1;

  // A clear request blocks the handshake in the same cycle, so a coincident character is dropped.
  assign out_char_ready = (state_reg == ST_IDLE) && !in_clear;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
      cursor_x_reg <= '0;
      cursor_y_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      cursor_x_reg <= cursor_x_next;
      cursor_y_reg <= cursor_y_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    cursor_x_next = cursor_x_reg;
    cursor_y_next = cursor_y_reg;
    wr_en         = 1'b0;
    wr_addr       = cursor_tile;
    wr_data       = in_char;
    case (state_reg)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr_reg;
        wr_data = CH_SPACE;
        if (clr_addr_reg == TILE_NUM_BITS'(NUM_TILES - 1)) begin
          state_next    = ST_IDLE;
          clr_addr_next = '0;
          cursor_x_next = '0;
          cursor_y_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + 1'b1;
        end
      end
      ST_IDLE: begin
        if (in_clear) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end else if (in_char_valid) begin
          if (in_char == CH_LF) begin
            cursor_x_next = '0;
            cursor_y_next = cursor_y_inc;
          end else if (in_char == CH_CR) begin
            cursor_x_next = '0;
          end else if (in_char == CH_BS) begin
            if (cursor_x_reg != '0) cursor_x_next = cursor_x_reg - 1'b1;
          end else begin
            wr_en = 1'b1;
            // No scrolling: running off the bottom row wraps to the top.
            if (cursor_x_reg == TILE_X_BITS'(NUM_TILES_X - 1)) begin
              cursor_x_next = '0;
              cursor_y_next = cursor_y_inc;
            end else begin
              cursor_x_next = cursor_x_reg + 1'b1;
            end
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (wr_en) text_mem[wr_addr] <= wr_data;
  end

  assign pix_tile = TILE_NUM_BITS'(in_vpage) * TILE_NUM_BITS'(NUM_TILES_X)
                  + TILE_NUM_BITS'(in_hpix >> COL_BITS);
  assign pix_col  = in_hpix[COL_BITS-1:0];

  // Read port is separate from the write port; a same-address collision yields the old code.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      font_char_reg <= '0;
      font_col_reg  <= '0;
    end else if (in_pix_req) begin
      font_char_reg <= text_mem[pix_tile];
      font_col_reg  <= pix_col;
    end
  end

`ifdef OLED_TEXT_CURSOR_EN
  localparam int BLINK_BITS = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_BITS-1:0] blink_cnt_reg;
  logic                  blink_phase_reg;
  logic                  hit_d1_reg, hit_d2_reg;
  logic                  hit_now;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (blink_cnt_reg == BLINK_BITS'(BLINK_CYCLES - 1)) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= !blink_phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  // Phase is sampled with the request so the inversion follows the request, not the output cycle.
  assign hit_now = (pix_tile == cursor_tile) && blink_phase_reg;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      hit_d1_reg <= 1'b0;
      hit_d2_reg <= 1'b0;
    end else begin
      hit_d1_reg <= in_pix_req && hit_now;
      hit_d2_reg <= hit_d1_reg;
    end
  end
`endif

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      req_d1_reg    <= 1'b0;
      req_d2_reg    <= 1'b0;
      pix_valid_reg <= 1'b0;
      pixels_reg    <= '0;
    end else begin
      req_d1_reg    <= in_pix_req;
      req_d2_reg    <= req_d1_reg;
      pix_valid_reg <= req_d2_reg;
      if (req_d2_reg) begin
`ifdef OLED_TEXT_CURSOR_EN
        pixels_reg <= hit_d2_reg ? ~in_font_column : in_font_column;
`else
        pixels_reg <= in_font_column;
`endif
      end
    end
  end

  assign out_font_char = font_char_reg;
  assign out_font_col  = font_col_reg;
  assign out_pixels    = pixels_reg;
  assign out_pix_valid = pix_valid_reg;
  assign out_cursor_x  = cursor_x_reg;
  assign out_cursor_y  = cursor_y_reg;

endmodule
